// File: rtl/strontium_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package strontium_mem_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ERROR   = 2'd3
    } arb_state_e;

    // Which requester owns the in-flight transaction.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam int DEFAULT_MEM_TIMEOUT = 16;
    localparam int TMO_CNT_W           = 16;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts read-wait cycles and flags when the limit is reached without data.
// Latency: expired is combinational in the cycle the count reaches limit.
// Backpressure: none; clear has priority over run.
// Ports: clk, reset (async active-low), clear, run, limit, expired.
module arb_timeout_counter
    import strontium_mem_pkg::*;
#(
    parameter int W = TMO_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The limit-th consecutive running cycle is the one that expires.
    assign expired = run && (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one transaction outstanding at a time; i_done/d_done are one-cycle pulses.
// Latency: read >= 3 cycles request-to-done, write >= 2; mem_ready stalls ISSUE,
// pause holds the core while any request is pending; a read with no mem_rvalid
// for MEM_TIMEOUT cycles locks into ERROR (err sticky) until reset.
// Ports: clk, reset (async active-low, released synchronously upstream);
//   i_req/i_addr -> i_done/i_rdata; d_req/d_we/d_addr/d_wdata -> d_done/d_rdata;
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rvalid/mem_rdata; pause, err.
// Option: define MEM_ARB_ROUND_ROBIN_EN to alternate contested grants
//   (otherwise data side always wins a contest).
module mem_port_arbiter
    import strontium_mem_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        pause,
    output logic        err
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(MEM_TIMEOUT);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;
    grant_e      pick;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        err_q, err_d;
    logic        tmo_expired;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e      last_q, last_d;
`endif

    // A request whose done pulse is showing this cycle is already served;
    // the requester only drops it on the following edge.
    logic i_pend, d_pend;
    assign i_pend = i_req & ~i_done_q;
    assign d_pend = d_req & ~d_done_q;

    always_comb begin
        if (i_pend && d_pend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
`else
            pick = GRANT_D;
`endif
        end else if (d_pend) begin
            pick = GRANT_D;
        end else begin
            pick = GRANT_I;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    state_d   = ISSUE;
                    grant_d   = pick;
                    mem_req_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d    = pick;
`endif
                    if (pick == GRANT_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        // Only the data side issues writes.
                        d_done_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (grant_q == GRANT_D) begin
                        d_rdata_d = mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_done_d  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
            ERROR: begin
                mem_req_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Starts at instruction so the first contest goes to data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= GRANT_I;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    arb_timeout_counter #(
        .W (TMO_CNT_W)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT_RD),
        .run     ((state_q == WAIT_RD) && !mem_rvalid),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    // err keeps the core held even if a requester later drops its request.
    assign pause     = (i_req & ~i_done_q) | (d_req & ~d_done_q) | err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: requesters push expected responses,
// a monitor pops them on every done pulse, a behavioural memory answers mem_*.
module tb_mem_port_arbiter;
    import strontium_mem_pkg::*;

    logic        clk, reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_req, mem_we, pause, err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, mem_rvalid;
    logic        resp_ready, resp_rvalid, man_ready, man_rvalid;
    logic [31:0] resp_rdata, man_rdata;

    assign mem_ready  = resp_ready | man_ready;
    assign mem_rvalid = resp_rvalid | man_rvalid;
    assign mem_rdata  = resp_rvalid ? resp_rdata : man_rdata;

    mem_port_arbiter #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pause(pause), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic is_wr; logic [31:0] data; } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        i_exp[$];
    exp_t        d_exp[$];
    grant_e      done_order[$];
    grant_e      last_served;
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];
    bit          resp_en;
    bit          no_rvalid;
    int          rdy_fix, rv_fix;
    logic [31:0] r_a, r_w;
    logic        r_we;
    int          r_dly;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return dflt(a);
    endfunction

    // Behavioural memory: random or fixed accept delay, then read data.
    initial begin
        resp_ready = 1'b0; resp_rvalid = 1'b0; resp_rdata = '0;
        forever begin
            @(negedge clk);
            resp_ready = 1'b0; resp_rvalid = 1'b0;
            if (resp_en && reset && mem_req) begin
                r_a = mem_addr; r_w = mem_wdata; r_we = mem_we;
                r_dly = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
                for (int k = 0; k < r_dly; k++) begin
                    @(negedge clk);
                    chk("mem_addr_stable", mem_addr, r_a);
                    chk("mem_wdata_stable", mem_wdata, r_w);
                    chk("mem_req_held", 32'(mem_req), 32'd1);
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                if (r_we) begin
                    mem_store[r_a] = r_w;
                end else if (!no_rvalid) begin
                    r_dly = (rv_fix >= 0) ? rv_fix : int'($urandom_range(1, 4));
                    for (int k = 1; k < r_dly; k++) @(negedge clk);
                    resp_rdata  = mem_read(r_a);
                    resp_rvalid = 1'b1;
                end
            end
        end
    end

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_done || d_done) chk("exclusive_done", 32'(i_done & d_done), 32'd0);
            if (i_done) begin
                if (i_exp.size() == 0) chk("unexpected_i_done", 32'(i_done), 32'd0);
                else begin
                    e = i_exp.pop_front();
                    chk("i_rdata", i_rdata, e.data);
                end
                last_served = GRANT_I;
                done_order.push_back(GRANT_I);
            end
            if (d_done) begin
                if (d_exp.size() == 0) chk("unexpected_d_done", 32'(d_done), 32'd0);
                else begin
                    e = d_exp.pop_front();
                    if (!e.is_wr) chk("d_rdata", d_rdata, e.data);
                end
                last_served = GRANT_D;
                done_order.push_back(GRANT_D);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        man_ready = 1'b0; man_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_served = GRANT_I;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input bit chg, input bit pchk, output int lat);
        exp_t e;
        e.is_wr = 1'b0; e.data = ref_read(addr);
        i_exp.push_back(e);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = addr;
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (pchk) chk("fetch_pause", 32'(pause), (n <= 2) ? 32'd1 : 32'd0);
            if (chg && n == 1) i_addr = ~addr;
            if (i_done) begin lat = n; break; end
        end
        if (lat < 0) chk("fetch_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int lat);
        exp_t e;
        e.is_wr = we;
        if (we) begin ref_mem[addr] = wd; e.data = '0; end
        else e.data = ref_read(addr);
        d_exp.push_back(e);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (d_done) begin lat = n; break; end
        end
        if (lat < 0) chk("data_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        int     lat_a, lat_b, tmo_n;
        grant_e ef;
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        resp_en = 1'b1; no_rvalid = 1'b0; rdy_fix = 0; rv_fix = 1;
        last_served = GRANT_I;
        ref_mem[32'h0040_0000]   = 32'h3C01_0040;
        mem_store[32'h0040_0000] = 32'h3C01_0040;
        do_reset();

        // Reset values
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);   chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);      chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_done", 32'(i_done), 0);     chk("rst_d_done", 32'(d_done), 0);
        chk("rst_i_rdata", i_rdata, 0);        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err", 32'(err), 0);           chk("rst_pause", 32'(pause), 0);

        // Minimum-latency fetch
        rdy_fix = 0; rv_fix = 1;
        do_fetch(32'h0040_0000, 1'b0, 1'b1, lat_a);
        chk("fetch_latency", 32'(lat_a), 32'd3);

        // Write with delayed accept
        rdy_fix = 3;
        do_data(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, lat_a);
        chk("write_latency", 32'(lat_a), 32'd5);
        rdy_fix = 0;
        do_data(1'b0, 32'h1001_0004, 32'h0, lat_a);

        // Fetch address changes while the request is being issued
        rdy_fix = 3; rv_fix = 2;
        do_fetch(32'h0040_0040, 1'b1, 1'b0, lat_a);

        // Contested rounds
        rdy_fix = 0; rv_fix = 1;
        for (int r = 0; r < 2; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ef = (last_served == GRANT_I) ? GRANT_D : GRANT_I;
`else
            ef = GRANT_D;
`endif
            done_order.delete();
            fork
                do_fetch(32'h0040_0100 + 32'(r * 4), 1'b0, 1'b0, lat_a);
                do_data(1'b0, 32'h1001_0100 + 32'(r * 4), 32'h0, lat_b);
            join
            chk("contest_count", 32'(done_order.size()), 32'd2);
            if (done_order.size() == 2) begin
                chk("contest_first", 32'(done_order[0]), 32'(ef));
                chk("contest_second", 32'(done_order[1]), 32'(ef == GRANT_D ? GRANT_I : GRANT_D));
            end
        end

        // Randomized concurrent traffic
        rdy_fix = -1; rv_fix = -1;
        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_fetch(32'h0040_0000 + 32'($urandom_range(0, 15) * 4), 1'b0, 1'b0, lat_a);
            end
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_data(1'($urandom_range(0, 1)), 32'h1001_0000 + 32'($urandom_range(0, 7) * 4),
                        $urandom, lat_b);
            end
        join

        // Read timeout into ERROR
        rdy_fix = 0; no_rvalid = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0040_0200;
        tmo_n = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (err) begin tmo_n = n; break; end
        end
        chk("timeout_cycle", 32'(tmo_n), 32'd18);
        chk("err_state", 32'(dut.state_q), 32'(ERROR));
        chk("err_mem_req", 32'(mem_req), 0);
        chk("err_pause", 32'(pause), 1);
        @(posedge clk); #1 man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        @(posedge clk); #1 man_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 1);
        chk("err_state_held", 32'(dut.state_q), 32'(ERROR));
        chk("err_no_i_done", 32'(i_done), 0);
        chk("err_pause_held", 32'(pause), 1);
        no_rvalid = 1'b0;
        do_reset();
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);
        chk("err_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset while waiting for read data, then a stale mem_rvalid
        resp_en = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0040_0300;
        @(negedge clk);
        @(negedge clk); man_ready = 1'b1;
        @(negedge clk); man_ready = 1'b0;
        chk("wait_rd_state", 32'(dut.state_q), 32'(WAIT_RD));
        #2 reset = 1'b0; i_req = 1'b0;
        #1;
        chk("async_state", 32'(dut.state_q), 32'(IDLE));
        chk("async_mem_addr", mem_addr, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1 man_rvalid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("late_rv_i_done", 32'(i_done), 0);
            chk("late_rv_i_rdata", i_rdata, 0);
        end
        chk("late_rv_mem_req", 32'(mem_req), 0);
        chk("late_rv_err", 32'(err), 0);
        chk("late_rv_d_rdata", d_rdata, 0);
        resp_en = 1'b1;

        // End-of-run consistency
        repeat (2) @(negedge clk);
        chk("i_exp_empty", 32'(i_exp.size()), 0);
        chk("d_exp_empty", 32'(d_exp.size()), 0);
        foreach (ref_mem[k]) chk("mem_content", mem_read(k), ref_mem[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
